// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mdu_pkg
// Description : Shared types and constants for the multiply/divide unit.
//               Operation codes, FSM state encoding, divider iteration count
//               and a two's-complement negate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // One quotient bit is produced per divider iteration.
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : mul_div_unit_if
// Description : Issue/result bundle between the EX/MEM pipeline stage and
//               the multiply/divide unit, including the HI/LO write port.
//   master (issuing stage) drives : start_i, op_i, src_a_i, src_b_i, cancel_i
//   slave  (mul_div_unit)  drives : busy_o, done_o, new_hi_o, w_hi_o,
//                                   new_lo_o, w_lo_o
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        cancel_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] new_hi_o;
  logic        w_hi_o;
  logic [31:0] new_lo_o;
  logic        w_lo_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, cancel_i,
    input  busy_o, done_o, new_hi_o, w_hi_o, new_lo_o, w_lo_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, cancel_i,
    output busy_o, done_o, new_hi_o, w_hi_o, new_lo_o, w_lo_o
  );
endinterface : mul_div_unit_if
`default_nettype wire

// File: rtl/mul_div_unit_div_radix2.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2
// Description : Radix-2 restoring divider datapath (no FSM). Captures raw
//               operands on load_i, converts them to magnitudes in a setup
//               cycle, then produces one quotient bit per run_i cycle.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : capture operands and sign information
//   signed_i      : operands are two's complement (DIV) vs unsigned (DIVU)
//   dividend_i    : raw dividend
//   divisor_i     : raw divisor (caller guarantees non-zero)
//   run_i         : advance one step (setup or iteration)
//   last_o        : current step is the final iteration
//   quot_o/rem_o  : sign-corrected result of the current iteration; valid
//                   to capture when last_o is high
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2
  import mdu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        run_i,
  output logic        last_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(DIV_ITERS);

  logic          setup_q,    setup_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [31:0]   rem_q,      rem_d;
  logic [31:0]   dvd_q,      dvd_d;     // dividend, shifts out as quotient shifts in
  logic [31:0]   dvs_q,      dvs_d;
  logic          neg_quot_q, neg_quot_d;
  logic          neg_rem_q,  neg_rem_d;  // also "dividend is negative"
  logic          neg_dvs_q,  neg_dvs_d;

  logic [32:0]   shift;
  logic          ge;
  logic [31:0]   rem_next;
  logic [31:0]   quot_next;

  // Partial remainder is always below the divisor, so the shifted value
  // fits in 33 bits and a non-negative difference fits back in 32.
  always_comb begin
    shift     = {rem_q, dvd_q[31]};
    ge        = (shift >= {1'b0, dvs_q});
    rem_next  = ge ? (shift[31:0] - dvs_q) : shift[31:0];
    quot_next = {dvd_q[30:0], ge};
  end

  always_comb begin
    setup_d    = setup_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    neg_dvs_d  = neg_dvs_q;
    if (load_i) begin
      setup_d    = 1'b1;
      cnt_d      = '0;
      rem_d      = '0;
      dvd_d      = dividend_i;
      dvs_d      = divisor_i;
      neg_quot_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
      neg_rem_d  = signed_i & dividend_i[31];
      neg_dvs_d  = signed_i & divisor_i[31];
    end else if (run_i) begin
      if (setup_q) begin
        // Absolute values are taken here rather than at capture so the
        // negate stays off the operand-forwarding path into the unit.
        setup_d = 1'b0;
        dvd_d   = neg_rem_q ? neg32(dvd_q) : dvd_q;
        dvs_d   = neg_dvs_q ? neg32(dvs_q) : dvs_q;
      end else begin
        rem_d = rem_next;
        dvd_d = quot_next;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      setup_q    <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      neg_dvs_q  <= 1'b0;
    end else begin
      setup_q    <= setup_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      neg_dvs_q  <= neg_dvs_d;
    end
  end

  assign last_o = run_i && !setup_q && (cnt_q == CW'(DIV_ITERS - 1));
  // The most negative dividend over -1 wraps back to itself, no trap.
  assign quot_o = neg_quot_q ? neg32(quot_next) : quot_next;
  assign rem_o  = neg_rem_q  ? neg32(rem_next)  : rem_next;

endmodule : div_radix2
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO
//               registers. Stalls the pipeline through busy_o and emits a
//               single write pulse on completion unless cancelled.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : start_i/op_i/src_a_i/src_b_i/cancel_i in,
//                  busy_o/done_o/new_hi_o/w_hi_o/new_lo_o/w_lo_o out
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  mul_div_unit_if.slave  bus
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  mdu_op_e     op_in;
  logic        accept;
  logic        div_load;
  logic        div_run;
  logic        div_last;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_prod;
  logic        write;

  assign op_in    = mdu_op_e'(bus.op_i);
  assign accept   = (state_q == S_IDLE) && bus.start_i && !bus.cancel_i;
  assign div_load = accept && op_in[1] && (bus.src_b_i != 32'd0);
  assign div_run  = (state_q == S_DIV) && !bus.cancel_i;

  // The low 64 bits of the product of 64-bit extended operands are exact
  // for both signed and unsigned interpretations.
  always_comb begin
    mul_signed = (op_q == MDU_MULT);
    mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
    mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
    mul_prod   = mul_a * mul_b;
  end

  div_radix2 u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (div_load),
    .signed_i   (op_in == MDU_DIV),
    .dividend_i (bus.src_a_i),
    .divisor_i  (bus.src_b_i),
    .run_i      (div_run),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op_in;
          a_d  = bus.src_a_i;
          b_d  = bus.src_b_i;
          if (!op_in[1]) begin
            state_d = S_MUL;
          end else if (bus.src_b_i != 32'd0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero skips the iterations entirely.
            state_d = S_DONE;
            hi_d    = bus.src_a_i;
            lo_d    = 32'hFFFF_FFFF;
          end
        end
      end
      S_MUL: begin
        if (bus.cancel_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          hi_d    = mul_prod[63:32];
          lo_d    = mul_prod[31:0];
        end
      end
      S_DIV: begin
        if (bus.cancel_i) begin
          state_d = S_IDLE;
        end else if (div_last) begin
          state_d = S_DONE;
          hi_d    = div_rem;
          lo_d    = div_quot;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A cancel arriving in the DONE cycle must still kill this cycle's write.
  assign write        = (state_q == S_DONE) && !bus.cancel_i;
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = write;
  assign bus.w_hi_o   = write;
  assign bus.w_lo_o   = write;
  assign bus.new_hi_o = hi_q;
  assign bus.new_lo_o = lo_q;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation in "cycle 0" and follow it to completion.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    bit gap;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    step();
    bus.start_i = 1'b0;
    cyc = 1;
    gap = 1'b0;
    while (bus.done_o !== 1'b1 && cyc < 60) begin
      if (bus.busy_o !== 1'b1) gap = 1'b1;
      step();
      cyc++;
    end
    chk({tag, ".done"},  {31'd0, bus.done_o}, 32'd1);
    chk({tag, ".cycle"}, cyc, exp_cyc);
    chk({tag, ".busy"},  {31'd0, bus.busy_o}, 32'd1);
    chk({tag, ".w_hi"},  {31'd0, bus.w_hi_o}, 32'd1);
    chk({tag, ".w_lo"},  {31'd0, bus.w_lo_o}, 32'd1);
    chk({tag, ".hi"},    bus.new_hi_o, exp_hi);
    chk({tag, ".lo"},    bus.new_lo_o, exp_lo);
    chk({tag, ".gap"},   {31'd0, gap}, 32'd0);
    step();
    chk({tag, ".busy_after"}, {31'd0, bus.busy_o}, 32'd0);
    chk({tag, ".done_after"}, {31'd0, bus.done_o}, 32'd0);
  endtask

  initial begin
    int writes;
    int dones;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.op_i     = 2'b00;
    bus.src_a_i  = '0;
    bus.src_b_i  = '0;
    bus.cancel_i = 1'b0;
    step();
    step();
    chk("rst.busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst.done", {31'd0, bus.done_o}, 32'd0);
    chk("rst.w_hi", {31'd0, bus.w_hi_o}, 32'd0);
    chk("rst.w_lo", {31'd0, bus.w_lo_o}, 32'd0);
    chk("rst.hi",   bus.new_hi_o, 32'd0);
    chk("rst.lo",   bus.new_lo_o, 32'd0);
    rst = 1'b0;

    run_op("mult_neg3x5",   2'b00, 32'hFFFF_FFFD, 32'd5,        2,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_min_3",    2'b11, 32'h8000_0000, 32'd3,        34, 32'h0000_0002, 32'h2AAA_AAAA);
    run_op("div_min_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
    run_op("div_100_m7",    2'b10, 32'd100,       32'hFFFF_FFF9, 34, 32'h0000_0002, 32'hFFFF_FFF2);
    run_op("divu_by_zero",  2'b11, 32'h0000_1234, 32'd0,        1,  32'h0000_1234, 32'hFFFF_FFFF);

    // Cancel in IDLE blocks acceptance.
    bus.start_i  = 1'b1;
    bus.cancel_i = 1'b1;
    bus.op_i     = 2'b10;
    bus.src_a_i  = 32'd50;
    bus.src_b_i  = 32'd5;
    step();
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    chk("idle_cancel.busy", {31'd0, bus.busy_o}, 32'd0);

    // Cancel pulsed in cycle 10 of a divide.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b10;
    bus.src_a_i = 32'd1000;
    bus.src_b_i = 32'd3;
    step();
    bus.start_i = 1'b0;
    writes = 0;
    for (int c = 1; c < 10; c++) begin
      if (bus.w_hi_o === 1'b1 || bus.w_lo_o === 1'b1) writes++;
      step();
    end
    bus.cancel_i = 1'b1;
    #1;
    if (bus.w_hi_o === 1'b1 || bus.w_lo_o === 1'b1) writes++;
    step();
    bus.cancel_i = 1'b0;
    if (bus.w_hi_o === 1'b1 || bus.w_lo_o === 1'b1) writes++;
    chk("div_cancel.busy11", {31'd0, bus.busy_o}, 32'd0);
    chk("div_cancel.writes", writes, 32'd0);
    run_op("mult_after_cancel", 2'b00, 32'd6, 32'd7, 2, 32'd0, 32'h0000_002A);

    // Cancel inside the DONE cycle suppresses the write combinationally.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.src_a_i = 32'd3;
    bus.src_b_i = 32'd3;
    step();
    bus.start_i = 1'b0;
    step();
    chk("done_cancel.pre_done", {31'd0, bus.done_o}, 32'd1);
    bus.cancel_i = 1'b1;
    #1;
    chk("done_cancel.w_hi", {31'd0, bus.w_hi_o}, 32'd0);
    chk("done_cancel.w_lo", {31'd0, bus.w_lo_o}, 32'd0);
    chk("done_cancel.done", {31'd0, bus.done_o}, 32'd0);
    step();
    bus.cancel_i = 1'b0;
    chk("done_cancel.busy", {31'd0, bus.busy_o}, 32'd0);

    // start_i held high while busy produces only one result.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.src_a_i = 32'h0001_0000;
    bus.src_b_i = 32'h0001_0000;
    step();
    step();
    chk("held.done", {31'd0, bus.done_o}, 32'd1);
    chk("held.hi",   bus.new_hi_o, 32'h0000_0001);
    chk("held.lo",   bus.new_lo_o, 32'h0000_0000);
    step();
    bus.start_i = 1'b0;
    chk("held.busy3", {31'd0, bus.busy_o}, 32'd0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done_o === 1'b1) dones++;
      step();
    end
    chk("held.extra_dones", dones, 32'd0);

    // Reset asserted in cycle 5 of a divide.
    bus.start_i = 1'b1;
    bus.op_i    = 2'b10;
    bus.src_a_i = 32'hFFFF_FFF9;
    bus.src_b_i = 32'd2;
    step();
    bus.start_i = 1'b0;
    for (int c = 1; c < 5; c++) step();
    chk("rst_mid.busy5", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_mid.done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_mid.hi",   bus.new_hi_o, 32'd0);
    chk("rst_mid.lo",   bus.new_lo_o, 32'd0);
    writes = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.w_hi_o === 1'b1 || bus.w_lo_o === 1'b1) writes++;
      step();
    end
    chk("rst_mid.writes", writes, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mul_div_unit
`default_nettype wire
